// File: rtl/mlops_pkg.sv
// rtl/mlops_pkg.sv - shared mlops types: shift FSM states and saturation bounds helper
package mlops_pkg;

  typedef enum logic {
    WAITING    = 1'b0,
    PROCESSING = 1'b1
  } shiftproc_state;

  typedef struct packed {
    logic signed [31:0] min_v;
    logic signed [31:0] max_v;
  } sat_bounds_t;

  // Two's-complement range of a signed value of the given width.
  function automatic sat_bounds_t sat_bounds(input int width);
    sat_bounds_t b;
    b.max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    b.min_v = -(32'sd1 <<< (width - 1));
    return b;
  endfunction

endpackage

// File: rtl/v_shift_sat_if.sv
// rtl/v_shift_sat_if.sv - chunk stream interface of the vector requantizer
interface v_shift_sat_if #(
  parameter int WorkingRegs = 4,
  parameter int InBits      = 16,
  parameter int OutBits     = 8,
  parameter int MaxShift    = 15
);
  localparam int ShiftW = $clog2(MaxShift + 1);

  logic                                      in_data_ready;
  logic signed [WorkingRegs-1:0][InBits-1:0] in_data;
  logic [ShiftW-1:0]                         shift_amt;
  logic                                      out_ready;
  logic                                      req_chunk_in;
  logic signed [WorkingRegs-1:0][OutBits-1:0] write_out_data;
  logic                                      req_chunk_out;
  logic                                      out_vector_valid;
  logic                                      sat_flag;

  modport master (
    output in_data_ready, in_data, shift_amt, out_ready,
    input  req_chunk_in, write_out_data, req_chunk_out, out_vector_valid, sat_flag
  );

  modport slave (
    input  in_data_ready, in_data, shift_amt, out_ready,
    output req_chunk_in, write_out_data, req_chunk_out, out_vector_valid, sat_flag
  );
endinterface

// File: rtl/v_shift_sat_lane.sv
// rtl/v_shift_sat_lane.sv - one lane: optional round (V_SHIFT_SAT_ROUND_EN), arithmetic shift, clamp, sat bit
module v_shift_sat_lane
  import mlops_pkg::*;
#(
  parameter int InBits  = 16,
  parameter int OutBits = 8,
  parameter int ShiftW  = 4
) (
  input  logic signed [InBits-1:0]  in_i,
  input  logic [ShiftW-1:0]         shift_i,
  output logic signed [InBits:0]    shifted_o,
  input  logic signed [InBits:0]    shifted_i,
  output logic signed [OutBits-1:0] out_o,
  output logic                      sat_o
);

  logic signed [InBits:0] x;
  sat_bounds_t            b;
  logic signed [31:0]     v;

  // First half (feeds S1): widen by one bit so the rounding bias cannot overflow, then shift.
  always_comb begin
    x = {in_i[InBits-1], in_i};
`ifdef V_SHIFT_SAT_ROUND_EN
    if (shift_i != '0) begin
      x = x + ((InBits + 1)'(1) << (shift_i - ShiftW'(1)));
    end
`endif
    shifted_o = x >>> shift_i;
  end

  // Second half (feeds S2): clamp the registered shifted value into the output range.
  always_comb begin
    b = sat_bounds(OutBits);
    v = 32'(shifted_i);
    if (v > b.max_v) begin
      out_o = OutBits'(b.max_v);
      sat_o = 1'b1;
    end else if (v < b.min_v) begin
      out_o = OutBits'(b.min_v);
      sat_o = 1'b1;
    end else begin
      out_o = OutBits'(v);
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/v_shift_sat.sv
// rtl/v_shift_sat.sv - chunked vector requantizer top; rounding selected by V_SHIFT_SAT_ROUND_EN in the lane
module v_shift_sat
  import mlops_pkg::*;
#(
  parameter int InVecLength = 10,
  parameter int WorkingRegs = 4,
  parameter int InBits      = 16,
  parameter int OutBits     = 8,
  parameter int MaxShift    = 15
) (
  input  logic clk_in,
  input  logic rst_in,
  v_shift_sat_if.slave bus
);

  localparam int NumChunks = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int LastLanes = InVecLength - (NumChunks - 1) * WorkingRegs;
  localparam int ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int ShiftW    = $clog2(MaxShift + 1);
  localparam int ValW      = InBits + 1;

  shiftproc_state state_q, state_d;
  logic [ChunkW-1:0] chunk_idx_q, chunk_idx_d;
  logic [ShiftW-1:0] shift_q, shift_d, shift_clamped, shift_eff;

  logic advance, accept, is_last_chunk, is_first_chunk;
  logic [WorkingRegs-1:0] lane_mask;

  logic [WorkingRegs-1:0][ValW-1:0]    shifted_w;
  logic [WorkingRegs-1:0][OutBits-1:0] sat_w;
  logic [WorkingRegs-1:0]              satbit_w;
  logic [WorkingRegs-1:0][OutBits-1:0] out_masked;

  logic                              s1_valid_q, s1_first_q, s1_last_q;
  logic [WorkingRegs-1:0]            s1_mask_q;
  logic [WorkingRegs-1:0][ValW-1:0]  s1_val_q;

  logic                                s2_valid_q, s2_last_q, acc_q;
  logic [WorkingRegs-1:0][OutBits-1:0] out_q;

  // The whole pipeline moves as one; a full S2 blocked downstream stalls everything.
  assign advance        = bus.out_ready || !s2_valid_q;
  assign accept         = bus.in_data_ready && advance;
  assign is_last_chunk  = (chunk_idx_q == ChunkW'(NumChunks - 1));
  assign is_first_chunk = (state_q == WAITING);
  assign shift_eff      = is_first_chunk ? shift_clamped : shift_q;

  // Out-of-range shift requests saturate at the largest legal shift.
  always_comb begin
    shift_clamped = bus.shift_amt;
    if (int'(bus.shift_amt) > MaxShift) begin
      shift_clamped = ShiftW'(MaxShift);
    end
  end

  for (genvar g = 0; g < WorkingRegs; g++) begin : g_lane
    v_shift_sat_lane #(
      .InBits (InBits),
      .OutBits(OutBits),
      .ShiftW (ShiftW)
    ) u_lane (
      .in_i     (bus.in_data[g]),
      .shift_i  (shift_eff),
      .shifted_o(shifted_w[g]),
      .shifted_i(s1_val_q[g]),
      .out_o    (sat_w[g]),
      .sat_o    (satbit_w[g])
    );
    assign lane_mask[g] = !is_last_chunk || (g < LastLanes);
  end

  // FSM and chunk counter state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= WAITING;
      chunk_idx_q <= '0;
      shift_q     <= '0;
    end else begin
      state_q     <= state_d;
      chunk_idx_q <= chunk_idx_d;
      shift_q     <= shift_d;
    end
  end

  // Next state: shift is captured only on the first chunk of each vector.
  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    shift_d     = shift_q;
    if (accept) begin
      chunk_idx_d = is_last_chunk ? '0 : chunk_idx_q + ChunkW'(1);
      case (state_q)
        WAITING: begin
          shift_d = shift_clamped;
          state_d = (NumChunks > 1) ? PROCESSING : WAITING;
        end
        PROCESSING: begin
          if (is_last_chunk) state_d = WAITING;
        end
        default: state_d = WAITING;
      endcase
    end
  end

  // S1: shifted values plus lane mask and first/last tags of the chunk.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mask_q  <= '0;
      s1_val_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_val_q   <= shifted_w;
        s1_mask_q  <= lane_mask;
        s1_first_q <= is_first_chunk;
        s1_last_q  <= is_last_chunk;
      end
    end
  end

  // Padding lanes of the partial last chunk read as zero.
  always_comb begin
    out_masked = '0;
    for (int i = 0; i < WorkingRegs; i++) begin
      if (s1_mask_q[i]) out_masked[i] = sat_w[i];
    end
  end

  // S2: saturated output and per-vector sat accumulator, restarted by the first chunk.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      acc_q      <= 1'b0;
      out_q      <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_q     <= out_masked;
        s2_last_q <= s1_last_q;
        acc_q     <= (s1_first_q ? 1'b0 : acc_q) | (|(satbit_w & s1_mask_q));
      end
    end
  end

  assign bus.req_chunk_in     = advance && rst_in;
  assign bus.req_chunk_out    = s2_valid_q && bus.out_ready;
  assign bus.out_vector_valid = bus.req_chunk_out && s2_last_q;
  assign bus.sat_flag         = bus.out_vector_valid && acc_q;
  assign bus.write_out_data   = out_q;

endmodule

// File: tb/tb_v_shift_sat.sv
// tb/tb_v_shift_sat.sv - randomized scoreboard bench for v_shift_sat
module tb_v_shift_sat;
  localparam int VL = 10;
  localparam int WR = 4;
  localparam int IB = 16;
  localparam int OB = 8;
  localparam int MS = 15;
  localparam int NC = 3;

  typedef struct {
    int d[WR];
    bit last;
    bit sat;
    int cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v_shift_sat_if #(.WorkingRegs(WR), .InBits(IB), .OutBits(OB), .MaxShift(MS)) bus ();

  v_shift_sat #(
    .InVecLength(VL), .WorkingRegs(WR), .InBits(IB), .OutBits(OB), .MaxShift(MS)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus)
  );

  rec_t exp_q[$];
  rec_t cap_q[$];
  int   acc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  bit   rnd_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: round (optional), floor-shift, clamp to the 8-bit signed range.
  function automatic int model_elem(input int x, input int sh, output bit sat);
    int y;
`ifdef V_SHIFT_SAT_ROUND_EN
    if (sh > 0) x = x + (1 << (sh - 1));
`endif
    y = x >>> sh;
    sat = 1'b0;
    if (y > 127) begin
      y = 127; sat = 1'b1;
    end else if (y < -128) begin
      y = -128; sat = 1'b1;
    end
    return y;
  endfunction

  function automatic int rnd_elem();
    if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  task automatic push_vector(input int v[VL], input int sh);
    rec_t rs[NC];
    bit s, any;
    int idx;
    any = 1'b0;
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < WR; l++) begin
        idx = c * WR + l;
        if (idx < VL) begin
          rs[c].d[l] = model_elem(v[idx], sh, s);
          any = any | s;
        end else begin
          rs[c].d[l] = 0;
        end
      end
      rs[c].last = (c == NC - 1);
      rs[c].sat  = 1'b0;
      rs[c].cyc  = 0;
    end
    rs[NC-1].sat = any;
    for (int c = 0; c < NC; c++) exp_q.push_back(rs[c]);
  endtask

  task automatic send_chunk(input int v[VL], input int c, input int sh);
    int waitc, idx;
    waitc = 0;
    @(negedge clk);
    bus.in_data_ready = 1'b1;
    bus.shift_amt = 4'(sh);
    for (int l = 0; l < WR; l++) begin
      idx = c * WR + l;
      bus.in_data[l] = (idx < VL) ? 16'(v[idx]) : 16'($urandom);
    end
    #1;
    while (!bus.req_chunk_in) begin
      waitc++;
      if (waitc > 200) begin
        errors++; checks++;
        $display("FAIL accept_timeout: got no req_chunk_in expected within 200 cycles");
        bus.in_data_ready = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    acc_q.push_back(cyc);
    @(posedge clk);
  endtask

  task automatic send_vector(input int v[VL], input int sh, input int later_sh, input bit gaps);
    push_vector(v, sh);
    for (int c = 0; c < NC; c++) begin
      send_chunk(v, c, (c == 0) ? sh : later_sh);
      if (gaps && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          bus.in_data_ready = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int k;
    @(negedge clk);
    bus.in_data_ready = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: got %0d pending chunks expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);

  // Single compare process: every output write is matched against the model queue.
  always begin : cmp
    rec_t a, e;
    @(negedge clk);
    #3;
    if (chk_en) begin
      if (bus.req_chunk_out) begin
        for (int l = 0; l < WR; l++) a.d[l] = $signed(bus.write_out_data[l]);
        a.last = bus.out_vector_valid;
        a.sat  = bus.sat_flag;
        a.cyc  = cyc;
        cap_q.push_back(a);
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_write: got write at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          for (int l = 0; l < WR; l++) check($sformatf("lane%0d", l), a.d[l], e.d[l]);
          check("out_vector_valid", int'(a.last), int'(e.last));
          check("sat_flag", int'(a.sat), int'(e.sat));
        end
      end else begin
        check("idle_qualifiers", int'({bus.out_vector_valid, bus.sat_flag}), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int v[VL], v2[VL];
    int low_seen;
    bus.in_data_ready = 1'b0;
    bus.in_data = '0;
    bus.shift_amt = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #3;
    check("rst_req_chunk_out", int'(bus.req_chunk_out), 0);
    check("rst_req_chunk_in", int'(bus.req_chunk_in), 0);
    check("rst_out_vector_valid", int'(bus.out_vector_valid), 0);
    check("rst_sat_flag", int'(bus.sat_flag), 0);
    check("rst_write_out_data", int'(bus.write_out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Plain shift by 4 and latency.
    for (int i = 0; i < VL; i++) v[i] = rnd_elem();
    v[0] = 256; v[1] = -256; v[2] = 0; v[3] = 16;
    cap_q.delete(); acc_q.delete();
    send_vector(v, 4, int'($urandom_range(0, 15)), 1'b0);
    drain();
    check("t1_writes", cap_q.size(), 3);
    if (cap_q.size() >= 1 && acc_q.size() >= 1) begin
      check("t1_l0", cap_q[0].d[0], 16);
      check("t1_l1", cap_q[0].d[1], -16);
      check("t1_l2", cap_q[0].d[2], 0);
      check("t1_l3", cap_q[0].d[3], 1);
      check("t1_latency", cap_q[0].cyc - acc_q[0], 2);
    end

    // Rounding versus truncation.
    for (int i = 0; i < VL; i++) v[i] = rnd_elem();
    v[0] = 24; v[1] = -24; v[2] = 8; v[3] = -8;
    cap_q.delete(); acc_q.delete();
    send_vector(v, 4, int'($urandom_range(0, 15)), 1'b0);
    drain();
    if (cap_q.size() >= 1) begin
`ifdef V_SHIFT_SAT_ROUND_EN
      check("t2_l0", cap_q[0].d[0], 2);
      check("t2_l1", cap_q[0].d[1], -1);
      check("t2_l2", cap_q[0].d[2], 1);
      check("t2_l3", cap_q[0].d[3], 0);
`else
      check("t2_l0", cap_q[0].d[0], 1);
      check("t2_l1", cap_q[0].d[1], -2);
      check("t2_l2", cap_q[0].d[2], 0);
      check("t2_l3", cap_q[0].d[3], -1);
`endif
    end else begin
      check("t2_writes", cap_q.size(), 3);
    end

    // Saturation flag set, then cleared by an all-zero vector.
    for (int i = 0; i < VL; i++) begin
      v[i] = int'($urandom_range(0, 200)) - 100;
      v2[i] = 0;
    end
    v[0] = 32767; v[1] = -32768;
    cap_q.delete(); acc_q.delete();
    send_vector(v, 0, 3, 1'b0);
    send_vector(v2, 0, 0, 1'b0);
    drain();
    check("t3_writes", cap_q.size(), 6);
    if (cap_q.size() >= 6) begin
      check("t3_pos_sat", cap_q[0].d[0], 127);
      check("t3_neg_sat", cap_q[0].d[1], -128);
      check("t3_sat_flag", int'(cap_q[2].sat), 1);
      check("t3_zero_sat_flag", int'(cap_q[5].sat), 0);
    end

    // Back-to-back vector, partial last chunk, shift change ignored mid-vector.
    for (int i = 0; i < VL; i++) v[i] = int'($urandom_range(0, 600)) - 300;
    cap_q.delete(); acc_q.delete();
    send_vector(v, 2, 7, 1'b0);
    drain();
    check("t4_writes", cap_q.size(), 3);
    if (cap_q.size() >= 3 && acc_q.size() >= 3) begin
      check("t4_pad2", cap_q[2].d[2], 0);
      check("t4_pad3", cap_q[2].d[3], 0);
      check("t4_last_flags", int'({cap_q[0].last, cap_q[1].last, cap_q[2].last}), 1);
      check("t4_accept_gap", acc_q[2] - acc_q[0], 2);
      check("t4_write_gap", cap_q[2].cyc - cap_q[0].cyc, 2);
    end

    // Backpressure mid-vector.
    for (int i = 0; i < VL; i++) v[i] = rnd_elem();
    cap_q.delete(); acc_q.delete();
    low_seen = 1;
    fork
      send_vector(v, 3, int'($urandom_range(0, 15)), 1'b0);
      begin
        for (int k = 0; k < 50 && acc_q.size() < 2; k++) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        low_seen = int'(bus.req_chunk_in);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t5_req_chunk_in_stalled", low_seen, 0);
    check("t5_writes", cap_q.size(), 3);

    // Asynchronous reset between chunks 1 and 2.
    chk_en = 1'b0;
    for (int i = 0; i < VL; i++) v[i] = rnd_elem();
    send_chunk(v, 0, 5);
    send_chunk(v, 1, 9);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_req_chunk_out", int'(bus.req_chunk_out), 0);
    check("t6_req_chunk_in", int'(bus.req_chunk_in), 0);
    check("t6_out_vector_valid", int'(bus.out_vector_valid), 0);
    check("t6_sat_flag", int'(bus.sat_flag), 0);
    check("t6_write_out_data", int'(bus.write_out_data), 0);
    @(negedge clk);
    bus.in_data_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    for (int i = 0; i < VL; i++) v[i] = int'($urandom_range(0, 4000)) - 2000;
    cap_q.delete(); acc_q.delete();
    send_vector(v, 6, 1, 1'b0);
    drain();
    check("t6_writes", cap_q.size(), 3);

    // Randomized stream with gaps and random backpressure.
    rnd_bp = 1'b1;
    repeat (25) begin
      for (int i = 0; i < VL; i++) v[i] = rnd_elem();
      send_vector(v, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
    end
    drain();
    rnd_bp = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
